// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle of the fetch-stage signals exchanged between
// fetch_ctrl and its neighbours (instruction unit, hazard unit, ID/EX).
//
// Signals:
//   stall              hazard unit request to hold PC and IF/ID
//   br_taken/br_target EX-stage taken branch and its word target
//   jmp/jmp_index      ID-stage J/JAL and its instr[25:0]
//   jr/jr_target       ID-stage JR/JALR and its register word target
//   halt               ID-stage halt instruction
//   instr_in           instruction word at pc (combinational from memory)
//   pc                 current fetch word address
//   if_id_instr/pc1/valid  IF/ID pipeline register
//   flush_id           combinational kill of the ID contents this cycle
//   halted             fetch is stopped until reset
//   fetch_cnt          instructions latched into IF/ID
//
// Handshake: there is no valid/ready pair here. Requests are level
// signals sampled on every rising edge; stall is a pure hold (nothing
// advances while it is high unless an EX branch overrides it), and
// if_id_valid qualifies the IF/ID contents for the consumer.
//
// Modports: slave = fetch_ctrl, master = the surrounding pipeline.
interface fetch_ctrl_if;
    logic        stall;
    logic        br_taken;
    logic [29:0] br_target;
    logic        jmp;
    logic [25:0] jmp_index;
    logic        jr;
    logic [29:0] jr_target;
    logic        halt;
    logic [31:0] instr_in;
    logic [29:0] pc;
    logic [31:0] if_id_instr;
    logic [29:0] if_id_pc1;
    logic        if_id_valid;
    logic        flush_id;
    logic        halted;
    logic [31:0] fetch_cnt;

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_index, jr, jr_target,
               halt, instr_in,
        output pc, if_id_instr, if_id_pc1, if_id_valid, flush_id, halted,
               fetch_cnt
    );

    modport master (
        output stall, br_taken, br_target, jmp, jmp_index, jr, jr_target,
               halt, instr_in,
        input  pc, if_id_instr, if_id_pc1, if_id_valid, flush_id, halted,
               fetch_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the word-addressed PC and the
// IF/ID pipeline register; picks the next PC among sequential, EX branch,
// ID register jump and ID absolute jump; inserts bubbles on redirects and
// halt, freezes on hazard stalls.
//
// Ports:
//   clk        pipeline clock (rising edge)
//   rst        asynchronous active-high reset
//   bus        fetch_ctrl_if.slave, see the interface for signal meanings
//   dbg_state  current FSM state (0 BOOT, 1 RUN, 2 HALT) for observation
module fetch_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [29:0] pc_inc;

    // Wraps modulo 2^30 by width.
    assign pc_inc = bus.pc + 30'd1;

    // Only an EX branch kills the ID instruction; a stall merely holds it.
    assign bus.flush_id = (state == RUN) && bus.br_taken;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= BOOT;
            bus.pc          <= RESET_PC;
            bus.if_id_instr <= 32'h0;
            bus.if_id_pc1   <= 30'h0;
            bus.if_id_valid <= 1'b0;
            bus.halted      <= 1'b0;
            bus.fetch_cnt   <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    // One idle cycle so the first fetch sees a settled pc.
                    state <= RUN;
                end

                RUN: begin
                    if (bus.br_taken) begin
                        // EX is older than anything stalled in ID, so it wins.
                        bus.pc          <= bus.br_target;
                        bus.if_id_instr <= 32'h0;
                        bus.if_id_pc1   <= 30'h0;
                        bus.if_id_valid <= 1'b0;
                    end else if (bus.stall) begin
                        // Hold everything; ID requests are re-evaluated later.
                    end else if (bus.if_id_valid && bus.jr) begin
                        bus.pc          <= bus.jr_target;
                        bus.if_id_instr <= 32'h0;
                        bus.if_id_pc1   <= 30'h0;
                        bus.if_id_valid <= 1'b0;
                    end else if (bus.if_id_valid && bus.jmp) begin
                        // Region bits come from PC+1 of the jump itself.
                        bus.pc          <= {bus.if_id_pc1[29:26], bus.jmp_index};
                        bus.if_id_instr <= 32'h0;
                        bus.if_id_pc1   <= 30'h0;
                        bus.if_id_valid <= 1'b0;
                    end else if (bus.if_id_valid && bus.halt) begin
                        bus.if_id_instr <= 32'h0;
                        bus.if_id_pc1   <= 30'h0;
                        bus.if_id_valid <= 1'b0;
                        bus.halted      <= 1'b1;
                        state           <= HALT;
                    end else begin
                        bus.pc          <= pc_inc;
                        bus.if_id_instr <= bus.instr_in;
                        bus.if_id_pc1   <= pc_inc;
                        bus.if_id_valid <= 1'b1;
                        bus.fetch_cnt   <= bus.fetch_cnt + 32'd1;
                    end
                end

                HALT: begin
                    // Frozen until reset.
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_w;

    fetch_ctrl_if m_if ();
    fetch_ctrl_if w_if ();

    fetch_ctrl #(.RESET_PC(30'h100)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (m_if.slave),
        .dbg_state (dbg_state)
    );

    fetch_ctrl #(.RESET_PC(30'h3FFFFFFF)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .bus       (w_if.slave),
        .dbg_state (dbg_state_w)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        br;
        logic [29:0] br_target;
        logic        jmp;
        logic [25:0] jmp_index;
        logic        jr;
        logic [29:0] jr_target;
        logic        halt;
        logic [31:0] instr;
        logic        exp_flush;
        logic [29:0] exp_pc;
        logic [31:0] exp_instr;
        logic [29:0] exp_pc1;
        logic        exp_valid;
        logic [31:0] exp_cnt;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic br, input logic [29:0] brt,
                       input logic jm, input logic [25:0] jix,
                       input logic jr, input logic [29:0] jrt, input logic hl,
                       input logic [31:0] ins, input logic efl,
                       input logic [29:0] epc, input logic [31:0] eins,
                       input logic [29:0] epc1, input logic ev,
                       input logic [31:0] ecnt, input logic eh);
        vec_t v;
        v.stall = st; v.br = br; v.br_target = brt; v.jmp = jm; v.jmp_index = jix;
        v.jr = jr; v.jr_target = jrt; v.halt = hl; v.instr = ins;
        v.exp_flush = efl; v.exp_pc = epc; v.exp_instr = eins; v.exp_pc1 = epc1;
        v.exp_valid = ev; v.exp_cnt = ecnt; v.exp_halted = eh;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic clear_inputs();
        m_if.stall = 0; m_if.br_taken = 0; m_if.br_target = '0;
        m_if.jmp = 0; m_if.jmp_index = '0; m_if.jr = 0; m_if.jr_target = '0;
        m_if.halt = 0; m_if.instr_in = '0;
        w_if.stall = 0; w_if.br_taken = 0; w_if.br_target = '0;
        w_if.jmp = 0; w_if.jmp_index = '0; w_if.jr = 0; w_if.jr_target = '0;
        w_if.halt = 0; w_if.instr_in = 32'h5555_0000;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input int idx, input vec_t v);
        string s;
        m_if.stall = v.stall; m_if.br_taken = v.br; m_if.br_target = v.br_target;
        m_if.jmp = v.jmp; m_if.jmp_index = v.jmp_index;
        m_if.jr = v.jr; m_if.jr_target = v.jr_target;
        m_if.halt = v.halt; m_if.instr_in = v.instr;
        #1;
        s = $sformatf("v%0d", idx);
        chk({s, ".flush_id"}, {31'h0, m_if.flush_id}, {31'h0, v.exp_flush});
        @(posedge clk);
        #1;
        chk({s, ".pc"}, {2'b0, m_if.pc}, {2'b0, v.exp_pc});
        chk({s, ".instr"}, m_if.if_id_instr, v.exp_instr);
        chk({s, ".pc1"}, {2'b0, m_if.if_id_pc1}, {2'b0, v.exp_pc1});
        chk({s, ".valid"}, {31'h0, m_if.if_id_valid}, {31'h0, v.exp_valid});
        chk({s, ".cnt"}, m_if.fetch_cnt, v.exp_cnt);
        chk({s, ".halted"}, {31'h0, m_if.halted}, {31'h0, v.exp_halted});
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        //   st br brt            jm jix      jr jrt     hl instr         fl pc            instr         pc1           v cnt h
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hDEAD0000, 0, 30'h100,      32'h0,        30'h0,        0, 0,  0); // BOOT
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000100, 0, 30'h101,      32'hA0000100, 30'h101,      1, 1,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000101, 0, 30'h102,      32'hA0000101, 30'h102,      1, 2,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000102, 0, 30'h103,      32'hA0000102, 30'h103,      1, 3,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000103, 0, 30'h104,      32'hA0000103, 30'h104,      1, 4,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000104, 0, 30'h105,      32'hA0000104, 30'h105,      1, 5,  0);
        add(1, 1, 30'h20,       0, 26'h0,   0, 30'h0,  0, 32'hA0000105, 1, 30'h20,       32'h0,        30'h0,        0, 5,  0); // branch beats stall
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000020, 0, 30'h21,       32'hA0000020, 30'h21,       1, 6,  0);
        add(0, 1, 30'h10000004, 0, 26'h0,   0, 30'h0,  0, 32'hA0000021, 1, 30'h10000004, 32'h0,        30'h0,        0, 6,  0);
        add(0, 0, 30'h0,        1, 26'h999, 0, 30'h0,  0, 32'h08000040, 0, 30'h10000005, 32'h08000040, 30'h10000005, 1, 7,  0); // jmp on bubble ignored
        add(1, 0, 30'h0,        1, 26'h40,  0, 30'h0,  0, 32'hB0000005, 0, 30'h10000005, 32'h08000040, 30'h10000005, 1, 7,  0); // stall beats jmp
        add(1, 0, 30'h0,        1, 26'h40,  0, 30'h0,  0, 32'hB0000005, 0, 30'h10000005, 32'h08000040, 30'h10000005, 1, 7,  0);
        add(0, 0, 30'h0,        1, 26'h40,  0, 30'h0,  0, 32'hB0000005, 0, 30'h10000040, 32'h0,        30'h0,        0, 7,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000040, 0, 30'h10000041, 32'hA0000040, 30'h10000041, 1, 8,  0);
        add(0, 1, 30'h50,       0, 26'h0,   1, 30'h300,0, 32'hA0000041, 1, 30'h50,       32'h0,        30'h0,        0, 8,  0); // branch beats jr
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000050, 0, 30'h51,       32'hA0000050, 30'h51,       1, 9,  0);
        add(0, 0, 30'h0,        0, 26'h0,   1, 30'h300,0, 32'hA0000051, 0, 30'h300,      32'h0,        30'h0,        0, 9,  0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hA0000300, 0, 30'h301,      32'hA0000300, 30'h301,      1, 10, 0);
        add(0, 1, 30'h70,       0, 26'h0,   0, 30'h0,  1, 32'hA0000301, 1, 30'h70,       32'h0,        30'h0,        0, 10, 0); // branch beats halt
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  0, 32'hFC000000, 0, 30'h71,       32'hFC000000, 30'h71,       1, 11, 0);
        add(0, 0, 30'h0,        0, 26'h0,   0, 30'h0,  1, 32'hA0000071, 0, 30'h71,       32'h0,        30'h0,        0, 11, 1); // enter HALT
        add(1, 1, 30'h5,        0, 26'h0,   0, 30'h0,  0, 32'hA0000072, 0, 30'h71,       32'h0,        30'h0,        0, 11, 1);
        add(0, 0, 30'h0,        1, 26'h7,   1, 30'h9,  1, 32'hA0000073, 0, 30'h71,       32'h0,        30'h0,        0, 11, 1);

        clear_inputs();
        rst = 1'b1;
        #12;
        chk("rst.pc", {2'b0, m_if.pc}, 32'h100);
        chk("rst.valid", {31'h0, m_if.if_id_valid}, 32'h0);
        chk("rst.instr", m_if.if_id_instr, 32'h0);
        chk("rst.pc1", {2'b0, m_if.if_id_pc1}, 32'h0);
        chk("rst.cnt", m_if.fetch_cnt, 32'h0);
        chk("rst.state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end
        chk("halt.state", {30'h0, dbg_state}, 32'h2);

        // Asynchronous reset out of HALT, no clock edge needed.
        clear_inputs();
        #2;
        rst = 1'b1;
        #2;
        chk("arst.pc", {2'b0, m_if.pc}, 32'h100);
        chk("arst.halted", {31'h0, m_if.halted}, 32'h0);
        chk("arst.cnt", m_if.fetch_cnt, 32'h0);
        chk("arst.state", {30'h0, dbg_state}, 32'h0);
        chk("wrap.rst.pc", {2'b0, w_if.pc}, 32'h3FFFFFFF);
        @(negedge clk);
        rst = 1'b0;
        m_if.instr_in = 32'hA0000100;

        // BOOT edge: nothing moves.
        @(posedge clk);
        #1;
        chk("boot.pc", {2'b0, m_if.pc}, 32'h100);
        chk("boot.valid", {31'h0, m_if.if_id_valid}, 32'h0);
        chk("boot.state", {30'h0, dbg_state}, 32'h1);
        chk("wrap.boot.pc", {2'b0, w_if.pc}, 32'h3FFFFFFF);

        // First fetch; wrap instance rolls over to 0.
        @(posedge clk);
        #1;
        chk("refetch.pc", {2'b0, m_if.pc}, 32'h101);
        chk("refetch.instr", m_if.if_id_instr, 32'hA0000100);
        chk("refetch.cnt", m_if.fetch_cnt, 32'h1);
        chk("wrap.pc", {2'b0, w_if.pc}, 32'h0);
        chk("wrap.pc1", {2'b0, w_if.if_id_pc1}, 32'h0);
        chk("wrap.valid", {31'h0, w_if.if_id_valid}, 32'h1);
        chk("wrap.instr", w_if.if_id_instr, 32'h55550000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the pipelined CPU. It owns the word-addressed program counter that drives the instruction unit, and it selects the next PC among sequential, branch (from EX), register jump and absolute jump (from ID). It also owns the IF/ID pipeline register, inserting bubbles on redirects and halt and freezing on hazard stalls. It sits between the instruction unit (instruction fetch and memory), the hazard unit and the ID/EX stages.

## Interface
- RESET_PC, 30'h0, word address loaded into `pc` on reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  30  EX-stage branch target (word address).
- jmp  in  1  ID-stage instruction is J/JAL.
- jmp_index  in  26  ID-stage instr[25:0].
- jr  in  1  ID-stage instruction is JR/JALR.
- jr_target  in  30  ID-stage register target (word address).
- halt  in  1  ID-stage instruction is halt.
- instr_in  in  32  instruction word at `pc`, from the instruction unit (combinational).
- pc  out  30  current fetch word address, to the instruction unit.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc1  out  30  IF/ID PC+1 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- flush_id  out  1  combinational; ID contents must not enter EX this cycle.
- halted  out  1  high in HALT state.
- fetch_cnt  out  32  count of instructions latched into IF/ID.

## Operation
- States: BOOT, RUN, HALT.
- Reset (async) values: `pc` = RESET_PC, `if_id_instr` = 0, `if_id_pc1` = 0, `if_id_valid` = 0, `fetch_cnt` = 0, state = BOOT.
- BOOT: lasts one cycle. PC and IF/ID are held, with `if_id_valid` = 0. Next state is RUN. All inputs are ignored.
- RUN, in priority order, evaluated each edge:
  1. `br_taken`: `pc` <= `br_target`. IF/ID becomes a bubble (valid 0, instr 0, pc1 0).
  2. `stall`: `pc` and IF/ID are held unchanged.
  3. `if_id_valid` & `jr`: `pc` <= `jr_target`. IF/ID becomes a bubble.
  4. `if_id_valid` & `jmp`: `pc` <= {`if_id_pc1`[29:26], `jmp_index`}. IF/ID becomes a bubble.
  5. `if_id_valid` & `halt`: `pc` is held. IF/ID becomes a bubble. State goes to HALT.
  6. Otherwise: `pc` <= `pc`+1. IF/ID <= {`instr_in`, `pc`+1, valid 1}. `fetch_cnt` += 1.
- `jmp`, `jr` and `halt` are ignored when `if_id_valid` = 0. A bubble never redirects.
- The architecture has no delay slot; the instruction fetched behind a taken jump or branch is squashed.
- `flush_id` = (state == RUN) & `br_taken`. A stalled ID is not flushed by the stall alone.
- HALT: `pc`, IF/ID (bubble) and `fetch_cnt` are frozen. All inputs are ignored. `halted` = 1. The only exit is `rst`.
- Arithmetic: `pc`+1 is modulo 2^30 (30'h3FFFFFFF -> 0). `fetch_cnt` wraps modulo 2^32.

## Timing
- One clock per fetch; `pc` changes only on rising edges.
- `if_id_*` is registered: it shows the instruction at `pc` one cycle after that `pc` was presented.
- Redirect latency: a branch or jump seen at edge N makes the target `pc` visible after N. The target instruction is in IF/ID after edge N+1. Penalty: 1 bubble for J/JR, 2 for EX branches (counting the ID squash via `flush_id`).
- Simultaneous `br_taken` & `stall`: the branch wins. The EX instruction is older, so the stalled ID instruction is killed.
- Simultaneous `stall` & `jmp`/`jr`/`halt`: the stall wins. The ID-side request is re-evaluated once the stall drops.
- Simultaneous `br_taken` & `halt`: the branch wins and HALT is not entered.
- `rst` asserted mid-operation, including in HALT: all state returns to reset values immediately (asynchronously), then BOOT applies after release.

## Test plan
- Reset with RESET_PC=30'h100, no requests: `pc` = 100 in BOOT. After edge 1 (BOOT->RUN) `pc` is still 100 with valid 0. After edge 2: `pc` = 101, `if_id_pc1` = 101, valid 1, `fetch_cnt` = 1.
- Sequential then `br_taken`=1 with `br_target`=30'h20 while `pc`=105: `flush_id`=1 that cycle. Next cycle `pc`=20 and IF/ID is a bubble. The following cycle `if_id_pc1`=21 and valid=1.
- `jmp`=1 with `jmp_index`=26'h40 and `if_id_pc1`=30'h1000_0005, plus `stall`=1 for 2 cycles: `pc` holds for 2 cycles. Then `pc`=30'h1000_0040 with an IF/ID bubble.
- `jr`=1 with `jr_target`=30'h300 and simultaneous `br_taken`=1 with `br_target`=30'h50: `pc`=50. `jr` is ignored.
- `halt` with valid IF/ID: next cycle `halted`=1 and `pc` frozen. Pulsing `br_taken` and `stall` has no effect and `fetch_cnt` is unchanged. Asserting `rst` returns to BOOT with `pc`=RESET_PC.
- RESET_PC=30'h3FFFFFFF: after the first fetch, `pc`=0 and `if_id_pc1`=0 with valid 1.
